// File: rtl/display7seg_pkg.sv
// display7seg_pkg: shared FSM states, segment constants and digit-to-pattern lookup
package display7seg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    case (d)
      4'd0: digit_pat = 7'b1000000;
      4'd1: digit_pat = 7'b1111001;
      4'd2: digit_pat = 7'b0100100;
      4'd3: digit_pat = 7'b0110000;
      4'd4: digit_pat = 7'b0011001;
      4'd5: digit_pat = 7'b0010010;
      4'd6: digit_pat = 7'b0000010;
      4'd7: digit_pat = 7'b1111000;
      4'd8: digit_pat = 7'b0000000;
      4'd9: digit_pat = 7'b0010000;
      default: digit_pat = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/display7seg_seq_seg7_encode.sv
// seg7_encode: one BCD digit plus blank/minus overrides to a 7-segment pattern
module seg7_encode
  import display7seg_pkg::*;
#(
  parameter int COMMON_ANODE = 0
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] pattern
);
  logic [6:0] base;
  assign base = minus ? SEG_MINUS : blank ? SEG_BLANK : digit_pat(digit);
  assign pattern = COMMON_ANODE != 0 ? ~base : base;
endmodule

// File: rtl/display7seg_seq.sv
// display7seg_seq: sequential double-dabble binary-to-BCD converter driving 7-segment digits
module display7seg_seq
  import display7seg_pkg::*;
#(
  parameter int BIN_WIDTH    = 32,
  parameter int DIGITS       = 8,
  parameter int COMMON_ANODE = 0,
  parameter int BLANK_LZ     = 1,
  parameter int SIGNED_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [BIN_WIDTH-1:0]  valor,
  output logic                  ready_out,
  output logic [DIGITS*7-1:0]   seg,
  output logic                  done,
  output logic                  ovf,
  output logic                  neg
);
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [6:0] BLANK_PAT = COMMON_ANODE != 0 ? ~SEG_BLANK : SEG_BLANK;
  state_t state, state_nx;
  logic [BIN_WIDTH-1:0] mag;
  logic [BW-1:0] bcd, bcd_adj;
  logic [CW-1:0] cnt;
  logic ovf_r, neg_r, fmt_ovf, take_neg;
  logic [DIGITS-1:0] shown, minus_at;
  logic [DIGITS*7-1:0] pat;
  int msd, mpos;
  assign ready_out = state == IDLE;
  assign take_neg = SIGNED_EN != 0 && valor[BIN_WIDTH-1];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (valid_in ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(BIN_WIDTH - 1) ? FORMAT : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      assign bcd_adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
      seg7_encode #(.COMMON_ANODE(COMMON_ANODE)) u_enc (
        .digit  (bcd[4*k+:4]),
        .blank  (!shown[k]),
        .minus  (minus_at[k]),
        .pattern(pat[7*k+:7])
      );
    end
  endgenerate
  // The minus sign sits just above the top shown digit; no room for it means overflow
  always_comb begin
    msd = 0;
    for (int i = 1; i < DIGITS; i++) if (bcd[4*i+:4] != 4'd0) msd = i;
    for (int i = 0; i < DIGITS; i++) shown[i] = BLANK_LZ == 0 || i <= msd;
    mpos = BLANK_LZ != 0 ? msd + 1 : DIGITS - 1;
    fmt_ovf = ovf_r || (neg_r && (mpos >= DIGITS || (BLANK_LZ == 0 && bcd[4*(DIGITS-1)+:4] != 4'd0)));
    for (int i = 0; i < DIGITS; i++) minus_at[i] = fmt_ovf || (neg_r && i == mpos);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf_r <= 1'b0;
      neg_r <= 1'b0;
      seg <= {DIGITS{BLANK_PAT}};
      done <= 1'b0;
      ovf <= 1'b0;
      neg <= 1'b0;
    end else begin
      done <= state == FORMAT;
      if (state == IDLE && valid_in) begin
        mag <= take_neg ? -valor : valor;
        neg_r <= take_neg;
        bcd <= '0;
        cnt <= '0;
        ovf_r <= 1'b0;
      end
      if (state == SHIFT) begin
        {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
        ovf_r <= ovf_r | bcd_adj[BW-1];
        cnt <= cnt + CW'(1);
      end
      if (state == FORMAT) begin
        seg <= pat;
        ovf <= fmt_ovf;
        neg <= neg_r;
      end
    end
endmodule
